// File: rtl/app_pkg.sv
// Shared types for the APP channel sequencer: FSM state encoding and synchroniser depth.
package app_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HIGH   = 3'd1,
    LOW    = 3'd2,
    TOHOLD = 3'd3,
    FULL   = 3'd4
  } app_state_e;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/app_vp_pulse.sv
// Retriggerable pulse stretcher: a 1-cycle trig yields a PULSE_CLKS-wide pulse,
// a retrigger while busy restarts the full width.
module app_vp_pulse #(
  parameter int PULSE_CLKS = 3
) (
  input  logic clk,
  input  logic rst_init,
  input  logic trig,
  output logic pulse
);

  localparam int PW = $clog2(PULSE_CLKS + 1);

  logic [PW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst_init)            r_cnt <= '0;
    else if (trig)           r_cnt <= PW'(PULSE_CLKS);
    else if (r_cnt != '0)    r_cnt <= r_cnt - PW'(1);
  end

  assign pulse = (r_cnt != '0);

endmodule

// File: rtl/app_chan_seq.sv
// APP channel event sequencer: synchronises vcomp, steps TOT events into ping/pong slots
// and fires per-event TAC pulses. Define APP_SEQ_WRAP_EN to wrap instead of holding FULL.
module app_chan_seq
  import app_pkg::*;
#(
  parameter int NSLOT      = 8,
  parameter int PULSE_CLKS = 3,
  parameter int TO_W       = 8,
  parameter int CNT_W      = $clog2(NSLOT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_init,
  input  logic                 vcomp,
  input  logic [TO_W-1:0]      timeout_cfg,
  input  logic                 read_en,
  output logic [NSLOT/2-1:0]   sample,
  output logic [NSLOT/2-1:0]   sampleP,
  output logic [NSLOT-1:0]     VP_front,
  output logic [NSLOT-1:0]     VP_back,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 timeout_evt,
  output logic                 overflow
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_vc_d;
  app_state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_k, w_k_nxt;
  logic [CNT_W-1:0]       r_count, w_count_nxt;
  logic [NSLOT-1:0]       r_slot, w_slot_nxt;
  logic [TO_W-1:0]        r_to, w_to_nxt;
  logic                   r_to_evt, w_to_evt_nxt;
  logic                   r_ovf, w_ovf_nxt;
  logic [NSLOT-1:0]       w_front_trig, w_back_trig;
  logic [NSLOT-1:0]       w_k_oh, w_p_oh;
  logic                   w_sync, w_rise, w_fall, w_to_hit, w_fall_go;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_sync & ~r_vc_d;
  assign w_fall   = ~w_sync & r_vc_d;
  assign w_to_hit = (timeout_cfg != '0) && (r_to == timeout_cfg - TO_W'(1));

  // Current slot and the opposite-phase slot it releases; after a wrap slot 0 pairs with NSLOT-1.
  always_comb begin
    w_k_oh = '0;
    w_p_oh = '0;
    for (int i = 0; i < NSLOT; i++) begin
      w_k_oh[i] = (r_k == CNT_W'(i));
      w_p_oh[i] = ((r_k != '0) && (r_k == CNT_W'(i + 1))) ||
                  (r_ovf && (r_k == '0) && (i == NSLOT - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst_init) begin
      r_sync   <= '0;
      r_vc_d   <= 1'b0;
      r_state  <= IDLE;
      r_k      <= '0;
      r_count  <= '0;
      r_slot   <= '0;
      r_to     <= '0;
      r_to_evt <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], vcomp};
      r_vc_d   <= w_sync;
      r_state  <= w_state_nxt;
      r_k      <= w_k_nxt;
      r_count  <= w_count_nxt;
      r_slot   <= w_slot_nxt;
      r_to     <= w_to_nxt;
      r_to_evt <= w_to_evt_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_k_nxt      = r_k;
    w_count_nxt  = r_count;
    w_slot_nxt   = r_slot;
    w_to_nxt     = r_to;
    w_to_evt_nxt = 1'b0;
    w_ovf_nxt    = r_ovf;
    w_front_trig = '0;
    w_back_trig  = '0;
    w_fall_go    = 1'b0;

    if (read_en) begin
      w_k_nxt     = '0;
      w_count_nxt = '0;
      w_slot_nxt  = '0;
      w_to_nxt    = '0;
      w_ovf_nxt   = 1'b0;
      w_state_nxt = w_sync ? TOHOLD : IDLE;
    end else begin
      case (r_state)
        IDLE, LOW: begin
          if (w_rise && (r_k < CNT_W'(NSLOT))) begin
            w_slot_nxt   = r_slot | w_k_oh;
            w_front_trig = w_k_oh;
            w_count_nxt  = r_ovf ? CNT_W'(NSLOT) : r_k + CNT_W'(1);
            w_to_nxt     = '0;
            w_state_nxt  = HIGH;
          end
        end
        HIGH: begin
          if (w_fall) begin
            w_fall_go = 1'b1;
          end else if (w_to_hit) begin
            w_fall_go    = 1'b1;
            w_to_evt_nxt = 1'b1;
          end else begin
            w_to_nxt = r_to + TO_W'(1);
          end
        end
        TOHOLD: begin
          if (!w_sync) w_state_nxt = (r_k == CNT_W'(NSLOT)) ? FULL : LOW;
        end
        default: ;
      endcase

      // Real or forced fall closes event k.
      if (w_fall_go) begin
        w_back_trig = w_k_oh;
        w_slot_nxt  = r_slot & ~w_p_oh;
        if (r_k == CNT_W'(NSLOT - 1)) begin
`ifdef APP_SEQ_WRAP_EN
          w_k_nxt    = '0;
          w_slot_nxt = w_slot_nxt & ~NSLOT'(1);
          w_ovf_nxt  = 1'b1;
`else
          w_k_nxt    = CNT_W'(NSLOT);
`endif
        end else begin
          w_k_nxt = r_k + CNT_W'(1);
        end
        if (w_to_evt_nxt)                  w_state_nxt = TOHOLD;
        else if (w_k_nxt == CNT_W'(NSLOT)) w_state_nxt = FULL;
        else                               w_state_nxt = LOW;
      end
    end
  end

  for (genvar g = 0; g < NSLOT; g++) begin : g_vp
    app_vp_pulse #(.PULSE_CLKS(PULSE_CLKS)) u_front (
      .clk(clk), .rst_init(rst_init), .trig(w_front_trig[g]), .pulse(VP_front[g])
    );
    app_vp_pulse #(.PULSE_CLKS(PULSE_CLKS)) u_back (
      .clk(clk), .rst_init(rst_init), .trig(w_back_trig[g]), .pulse(VP_back[g])
    );
  end

  for (genvar g = 0; g < NSLOT / 2; g++) begin : g_slot
    assign sample[g]  = r_slot[2*g];
    assign sampleP[g] = r_slot[2*g+1];
  end

  assign count       = r_count;
  assign full        = (r_state == FULL);
  assign timeout_evt = r_to_evt;
`ifdef APP_SEQ_WRAP_EN
  assign overflow    = r_ovf;
`else
  assign overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_app_chan_seq.sv
// Directed bench for app_chan_seq (NSLOT=8, PULSE_CLKS=3, timeout_cfg=10).
module tb_app_chan_seq;

  logic       clk = 1'b0;
  logic       rst_init, vcomp, read_en;
  logic [7:0] timeout_cfg;
  logic [3:0] sample, sampleP;
  logic [7:0] VP_front, VP_back;
  logic [3:0] count;
  logic       full, timeout_evt, overflow;
  int         checks = 0;
  int         errors = 0;

  app_chan_seq #(.NSLOT(8), .PULSE_CLKS(3), .TO_W(8)) dut (
    .clk(clk), .rst_init(rst_init), .vcomp(vcomp), .timeout_cfg(timeout_cfg), .read_en(read_en),
    .sample(sample), .sampleP(sampleP), .VP_front(VP_front), .VP_back(VP_back),
    .count(count), .full(full), .timeout_evt(timeout_evt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tot(input int hi, input int lo);
    vcomp = 1'b1; tick(hi);
    vcomp = 1'b0; tick(lo);
  endtask

  task automatic do_read();
    read_en = 1'b1; tick(1); read_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_init = 1'b1; vcomp = 1'b0; read_en = 1'b0; timeout_cfg = 8'd10;
    tick(3);
    rst_init = 1'b0; tick(1);
    checks++; if (sample !== 4'h0)   begin errors++; $display("FAIL reset_sample got %h exp 0", sample); end
    checks++; if (sampleP !== 4'h0)  begin errors++; $display("FAIL reset_sampleP got %h exp 0", sampleP); end
    checks++; if (VP_front !== 8'h0 || VP_back !== 8'h0) begin errors++; $display("FAIL reset_vp got %h/%h exp 0/0", VP_front, VP_back); end
    checks++; if (count !== 4'd0 || full !== 1'b0) begin errors++; $display("FAIL reset_cnt got %0d/%b exp 0/0", count, full); end
    checks++; if (timeout_evt !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags got %b/%b exp 0/0", timeout_evt, overflow); end
  endtask

  task automatic test_single();
    vcomp = 1'b1; tick(3);
    checks++; if (sample !== 4'b0001) begin errors++; $display("FAIL t1_sample got %b exp 0001", sample); end
    checks++; if (VP_front !== 8'h01 || count !== 4'd1) begin errors++; $display("FAIL t1_front got %h/%0d exp 01/1", VP_front, count); end
    tick(2);
    checks++; if (VP_front !== 8'h01) begin errors++; $display("FAIL t1_front_w3 got %h exp 01", VP_front); end
    vcomp = 1'b0; tick(1);
    checks++; if (VP_front !== 8'h00) begin errors++; $display("FAIL t1_front_end got %h exp 00", VP_front); end
    tick(2);
    checks++; if (VP_back !== 8'h01 || sample !== 4'b0001 || count !== 4'd1) begin errors++; $display("FAIL t1_fall got %h/%b/%0d exp 01/0001/1", VP_back, sample, count); end
    tick(2);
    checks++; if (VP_back !== 8'h01) begin errors++; $display("FAIL t1_back_w3 got %h exp 01", VP_back); end
    tick(1);
    checks++; if (VP_back !== 8'h00) begin errors++; $display("FAIL t1_back_end got %h exp 00", VP_back); end
  endtask

  task automatic test_two();
    do_read();
    checks++; if (count !== 4'd0 || sample !== 4'h0) begin errors++; $display("FAIL t2_read got %0d/%b exp 0/0000", count, sample); end
    tot(3, 4);
    vcomp = 1'b1; tick(3);
    checks++; if (sampleP !== 4'b0001 || sample !== 4'b0001 || count !== 4'd2) begin errors++; $display("FAIL t2_rise got %b/%b/%0d exp 0001/0001/2", sampleP, sample, count); end
    checks++; if (VP_front !== 8'h02) begin errors++; $display("FAIL t2_front got %h exp 02", VP_front); end
    vcomp = 1'b0; tick(3);
    checks++; if (sample !== 4'b0000 || sampleP !== 4'b0001 || count !== 4'd2) begin errors++; $display("FAIL t2_fall got %b/%b/%0d exp 0000/0001/2", sample, sampleP, count); end
    checks++; if (VP_back !== 8'h02) begin errors++; $display("FAIL t2_back got %h exp 02", VP_back); end
    tick(4);
  endtask

  task automatic test_full();
    do_read();
    for (int i = 0; i < 8; i++) tot(4, 4);
    checks++; if (full !== 1'b1 || count !== 4'd8) begin errors++; $display("FAIL t3_full got %b/%0d exp 1/8", full, count); end
    checks++; if (sample !== 4'b0000 || sampleP !== 4'b1000) begin errors++; $display("FAIL t3_slots got %b/%b exp 0000/1000", sample, sampleP); end
    vcomp = 1'b1; tick(4);
    checks++; if (VP_front !== 8'h00 || count !== 4'd8) begin errors++; $display("FAIL t3_ninth_rise got %h/%0d exp 00/8", VP_front, count); end
    vcomp = 1'b0; tick(4);
    checks++; if (VP_back !== 8'h00 || full !== 1'b1) begin errors++; $display("FAIL t3_ninth_fall got %h/%b exp 00/1", VP_back, full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t3_ovf got %b exp 0", overflow); end
    do_read();
    checks++; if (full !== 1'b0 || count !== 4'd0 || sample !== 4'h0 || sampleP !== 4'h0) begin errors++; $display("FAIL t3_read got %b/%0d/%b/%b exp 0/0/0/0", full, count, sample, sampleP); end
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    do_read();
    vcomp = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin tick(1); seen = VP_front[0]; end
    checks++; if (!seen) begin errors++; $display("FAIL t4_front_wait got 0 exp 1"); end
    n = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin tick(1); n++; seen = timeout_evt; end
    checks++; if (!seen || n !== 10) begin errors++; $display("FAIL t4_to_delay got %0d exp 10", n); end
    checks++; if (VP_back !== 8'h01 || count !== 4'd1) begin errors++; $display("FAIL t4_forced got %h/%0d exp 01/1", VP_back, count); end
    tick(1);
    checks++; if (timeout_evt !== 1'b0) begin errors++; $display("FAIL t4_evt_len got %b exp 0", timeout_evt); end
    tick(16);
    vcomp = 1'b0; tick(5);
    checks++; if (VP_back !== 8'h00 || count !== 4'd1 || sample !== 4'b0001) begin errors++; $display("FAIL t4_real_fall got %h/%0d/%b exp 00/1/0001", VP_back, count, sample); end
    vcomp = 1'b1; tick(3);
    checks++; if (VP_front !== 8'h02 || sampleP !== 4'b0001 || count !== 4'd2) begin errors++; $display("FAIL t4_next got %h/%b/%0d exp 02/0001/2", VP_front, sampleP, count); end
    vcomp = 1'b0; tick(3);
    checks++; if (VP_back !== 8'h02) begin errors++; $display("FAIL t4_next_back got %h exp 02", VP_back); end
    tick(4);
  endtask

  task automatic test_read_vs_rise();
    do_read(); tick(2);
    vcomp = 1'b1; tick(2);
    read_en = 1'b1; tick(1); read_en = 1'b0;
    checks++; if (count !== 4'd0 || sample !== 4'h0) begin errors++; $display("FAIL t5_drop got %0d/%b exp 0/0000", count, sample); end
    tick(2);
    checks++; if (VP_front !== 8'h00 || count !== 4'd0) begin errors++; $display("FAIL t5_nofront got %h/%0d exp 00/0", VP_front, count); end
    vcomp = 1'b0; tick(4);
    vcomp = 1'b1; tick(3);
    checks++; if (VP_front !== 8'h01 || sample !== 4'b0001 || count !== 4'd1) begin errors++; $display("FAIL t5_after got %h/%b/%0d exp 01/0001/1", VP_front, sample, count); end
    vcomp = 1'b0; tick(6);
  endtask

  task automatic test_wrap();
    do_read();
    for (int i = 0; i < 8; i++) tot(4, 4);
    checks++; if (overflow !== 1'b1 || count !== 4'd8 || full !== 1'b0) begin errors++; $display("FAIL t6_wrap got %b/%0d/%b exp 1/8/0", overflow, count, full); end
    vcomp = 1'b1; tick(3);
    checks++; if (sample !== 4'b0001 || count !== 4'd8 || VP_front !== 8'h01) begin errors++; $display("FAIL t6_reuse got %b/%0d/%h exp 0001/8/01", sample, count, VP_front); end
    vcomp = 1'b0; tick(4);
    rst_init = 1'b1; tick(1); rst_init = 1'b0;
    checks++; if (overflow !== 1'b0 || count !== 4'd0 || sample !== 4'h0 || sampleP !== 4'h0) begin errors++; $display("FAIL t6_rst got %b/%0d/%b/%b exp 0/0/0/0", overflow, count, sample, sampleP); end
  endtask

  task automatic test_rst_mid_pulse();
    do_read();
    vcomp = 1'b1; tick(3);
    checks++; if (VP_front !== 8'h01) begin errors++; $display("FAIL t7_pre got %h exp 01", VP_front); end
    rst_init = 1'b1; tick(1);
    checks++; if (VP_front !== 8'h00 || count !== 4'd0 || sample !== 4'h0) begin errors++; $display("FAIL t7_kill got %h/%0d/%b exp 00/0/0", VP_front, count, sample); end
    vcomp = 1'b0; tick(2); rst_init = 1'b0; tick(1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
`ifdef APP_SEQ_WRAP_EN
    test_wrap();
`else
    test_full();
`endif
    test_timeout();
    test_read_vs_rise();
    test_rst_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
